// File: rtl/operand_tf_pkg.sv
// Shared types and the saturating-shift helper for the operand transformer.
package operand_tf_pkg;

  typedef enum logic [1:0] {
    SHARE_2    = 2'd0,
    SHARE_4    = 2'd1,
    SHARE_8    = 2'd2,
    SHARE_RSVD = 2'd3
  } share_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Working width for the shift; wide enough for any legal element/scale pair.
  localparam int unsigned CALC_W = 64;

  // Shift a sign-extended value left by sh and clamp it to a signed out_w range.
  // sat reports whether clamping happened.
  function automatic logic signed [CALC_W-1:0] sat_shift(
    input  logic signed [CALC_W-1:0] x,
    input  int unsigned              sh,
    input  int unsigned              out_w,
    output logic                     sat
  );
    logic signed [CALC_W-1:0] full, hi, lo;
    full = x <<< sh;
    hi   = $signed((64'd1 << (out_w - 1)) - 64'd1);
    lo   = -hi - 64'sd1;
    sat  = (full > hi) || (full < lo);
    if (full > hi)      return hi;
    else if (full < lo) return lo;
    else                return full;
  endfunction

endpackage

// File: rtl/operand_transformer_param_if.sv
// Input/output vector handshake bundle for the operand transformer.
interface operand_transformer_param_if #(
  parameter int NUM_ELEMS  = 32,
  parameter int ELEM_W_IN  = 8,
  parameter int ELEM_W_OUT = 12,
  parameter int SCALE_W    = 3
);
  logic                                valid_in;
  logic                                ready_in;
  logic [NUM_ELEMS*ELEM_W_IN-1:0]      elems_in;
  logic [(NUM_ELEMS/2)*SCALE_W-1:0]    scales_in;
  logic [1:0]                          share_mode_in;
  logic                                valid_out;
  logic                                ready_out;
  logic [NUM_ELEMS*ELEM_W_OUT-1:0]     elems_out;
  logic                                sat_out;
  logic                                err_out;

  // Upstream producer plus downstream consumer (bench / surrounding pipeline).
  modport master (
    output valid_in, elems_in, scales_in, share_mode_in, ready_out,
    input  ready_in, valid_out, elems_out, sat_out, err_out
  );

  // The transformer itself.
  modport slave (
    input  valid_in, elems_in, scales_in, share_mode_in, ready_out,
    output ready_in, valid_out, elems_out, sat_out, err_out
  );
endinterface

// File: rtl/operand_tf_sat_lane.sv
// One combinational lane: sign-extend, shift by micro-scale, saturate.
module operand_tf_sat_lane
  import operand_tf_pkg::*;
#(
  parameter int ELEM_W_IN  = 8,
  parameter int ELEM_W_OUT = 12,
  parameter int SCALE_W    = 3
)(
  input  logic [ELEM_W_IN-1:0]  elem,
  input  logic [SCALE_W-1:0]    scale,
  output logic [ELEM_W_OUT-1:0] result,
  output logic                  sat
);
  logic signed [CALC_W-1:0] res_val;

  // Full-width shift and clamp; the clamped value always fits ELEM_W_OUT bits.
  always_comb begin
    res_val = sat_shift(CALC_W'($signed(elem)), 32'(scale), ELEM_W_OUT, sat);
    result  = ELEM_W_OUT'(res_val);
  end
endmodule

// File: rtl/operand_transformer_param.sv
// Streaming operand transformer: a vector of NUM_ELEMS elements is shifted and
// saturated on NUM_LANES lanes over ITERS cycles, then presented whole.
module operand_transformer_param
  import operand_tf_pkg::*;
#(
  parameter int NUM_ELEMS  = 32,
  parameter int NUM_LANES  = 16,
  parameter int ELEM_W_IN  = 8,
  parameter int ELEM_W_OUT = 12,
  parameter int SCALE_W    = 3
)(
  input logic clk,
  input logic rst_n,
  operand_transformer_param_if.slave bus
);
  localparam int ITERS      = NUM_ELEMS / NUM_LANES;
  localparam int NUM_SCALES = NUM_ELEMS / 2;
  localparam int K_W        = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int E_W        = $clog2(NUM_ELEMS);
  localparam int S_W        = E_W - 1;

  if (NUM_ELEMS < 8 || (NUM_ELEMS & (NUM_ELEMS - 1)) != 0) begin : g_chk_elems
    $error("NUM_ELEMS must be a power of 2 and at least 8");
  end
  if (NUM_LANES < 1 || NUM_LANES > NUM_ELEMS ||
      ((NUM_LANES < 1) ? 1 : (NUM_ELEMS % NUM_LANES)) != 0) begin : g_chk_lanes
    $error("NUM_LANES must divide NUM_ELEMS");
  end
  if (ELEM_W_OUT <= ELEM_W_IN) begin : g_chk_wout
    $error("ELEM_W_OUT must exceed ELEM_W_IN");
  end
  if (ELEM_W_IN + (1 << SCALE_W) - 1 > CALC_W) begin : g_chk_calc
    $error("element/scale widths exceed the shift working width");
  end

  state_e                                state, state_nxt;
  logic [K_W-1:0]                        k, k_nxt;
  logic [NUM_ELEMS-1:0][ELEM_W_IN-1:0]   buf_elems;
  logic [NUM_SCALES-1:0][SCALE_W-1:0]    buf_scales;
  share_mode_e                           buf_mode;
  logic [NUM_ELEMS-1:0][ELEM_W_OUT-1:0]  tmp, merged;
  logic                                  tmp_sat;
  logic [NUM_LANES-1:0][E_W-1:0]         e_idx;
  logic [NUM_LANES-1:0][ELEM_W_IN-1:0]   lane_elem;
  logic [NUM_LANES-1:0][SCALE_W-1:0]     lane_scale;
  logic [NUM_LANES-1:0][ELEM_W_OUT-1:0]  lane_res;
  logic [NUM_LANES-1:0]                  lane_sat;
  logic [1:0]                            eff_mode;
  logic                                  lane_sat_any, vec_sat;
  logic                                  is_last, slot_free, commit, accept;

  // Reserved mode falls back to one scale per two elements.
  assign eff_mode = (buf_mode == SHARE_RSVD) ? 2'd0 : 2'(buf_mode);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [S_W-1:0] s_idx;
    // Lane l handles element l*ITERS + k in iteration k.
    assign e_idx[l]      = E_W'(l * ITERS) + E_W'(k);
    assign s_idx         = S_W'(e_idx[l] >> (eff_mode + 2'd1));
    assign lane_elem[l]  = buf_elems[e_idx[l]];
    assign lane_scale[l] = buf_scales[s_idx];

    operand_tf_sat_lane #(
      .ELEM_W_IN (ELEM_W_IN),
      .ELEM_W_OUT(ELEM_W_OUT),
      .SCALE_W   (SCALE_W)
    ) u_lane (
      .elem  (lane_elem[l]),
      .scale (lane_scale[l]),
      .result(lane_res[l]),
      .sat   (lane_sat[l])
    );
  end

  assign lane_sat_any = |lane_sat;
  // Earlier iterations only count once we are past iteration 0.
  assign vec_sat      = lane_sat_any | ((k != '0) & tmp_sat);

  assign is_last   = (state == ST_WAIT) || (state == ST_PROC && k == K_W'(ITERS - 1));
  assign slot_free = !bus.valid_out || bus.ready_out;
  assign commit    = is_last && slot_free;
  assign bus.ready_in = (state == ST_IDLE) || commit;
  assign accept    = bus.valid_in && bus.ready_in;

  // Temp array with the current iteration's lane results folded in.
  always_comb begin
    merged = tmp;
    for (int l = 0; l < NUM_LANES; l++) merged[e_idx[l]] = lane_res[l];
  end

  // Next-state and iteration counter.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_PROC;
        k_nxt     = '0;
      end
      ST_PROC, ST_WAIT: begin
        if (is_last) begin
          if (slot_free) begin
            state_nxt = accept ? ST_PROC : ST_IDLE;
            k_nxt     = '0;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          k_nxt = k + K_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Input buffer: captured on accept, held through PROC/WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_elems  <= '0;
      buf_scales <= '0;
      buf_mode   <= SHARE_2;
    end else if (accept) begin
      buf_elems  <= bus.elems_in;
      buf_scales <= bus.scales_in;
      buf_mode   <= share_mode_e'(bus.share_mode_in);
    end
  end

  // Temp array and running saturation flag, written every busy cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmp     <= '0;
      tmp_sat <= 1'b0;
    end else if (state != ST_IDLE) begin
      tmp     <= merged;
      tmp_sat <= vec_sat;
    end
  end

  // Output register: load on commit, drop valid on a plain drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.valid_out <= 1'b0;
      bus.elems_out <= '0;
      bus.sat_out   <= 1'b0;
      bus.err_out   <= 1'b0;
    end else if (commit) begin
      bus.valid_out <= 1'b1;
      bus.elems_out <= merged;
      bus.sat_out   <= vec_sat;
      bus.err_out   <= (buf_mode == SHARE_RSVD);
    end else if (bus.ready_out) begin
      bus.valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_transformer_param.sv
// Bench for operand_transformer_param: default 16-lane instance plus a
// 32-lane (single-iteration) instance for streaming.
module tb_operand_transformer_param;
  localparam int NE = 32, WI = 8, WO = 12, SW = 3, NS = NE / 2;
  localparam int EW = NE * WI, SWW = NS * SW, OW = NE * WO;
  typedef logic [EW-1:0]  ev_t;
  typedef logic [SWW-1:0] sv_t;
  typedef logic [OW-1:0]  ov_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  ov_t q_a[$];
  ov_t q_b[$];
  int  qc_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_transformer_param_if #(.NUM_ELEMS(NE), .ELEM_W_IN(WI), .ELEM_W_OUT(WO), .SCALE_W(SW)) bus_a ();
  operand_transformer_param_if #(.NUM_ELEMS(NE), .ELEM_W_IN(WI), .ELEM_W_OUT(WO), .SCALE_W(SW)) bus_b ();

  operand_transformer_param #(.NUM_ELEMS(NE), .NUM_LANES(16), .ELEM_W_IN(WI), .ELEM_W_OUT(WO), .SCALE_W(SW))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  operand_transformer_param #(.NUM_ELEMS(NE), .NUM_LANES(32), .ELEM_W_IN(WI), .ELEM_W_OUT(WO), .SCALE_W(SW))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Record every output handshake (taken at the following rising edge).
  always @(negedge clk) begin
    if (bus_a.valid_out && bus_a.ready_out) q_a.push_back(bus_a.elems_out);
    if (bus_b.valid_out && bus_b.ready_out) begin
      q_b.push_back(bus_b.elems_out);
      qc_b.push_back(cyc);
    end
  end

  // Reference: each element times 2^scale, clamped to the output range.
  function automatic void model(input ev_t ev, input sv_t sv, input logic [1:0] mode,
                                output ov_t ov, output logic sat);
    int m, v, sh;
    sat = 1'b0;
    ov  = '0;
    m   = (mode == 2'd3) ? 0 : int'(mode);
    for (int e = 0; e < NE; e++) begin
      sh = int'(sv[(e >> (m + 1)) * SW +: SW]);
      v  = int'($signed(ev[e * WI +: WI])) * (1 << sh);
      if (v > (1 << (WO - 1)) - 1) begin v = (1 << (WO - 1)) - 1; sat = 1'b1; end
      else if (v < -(1 << (WO - 1))) begin v = -(1 << (WO - 1)); sat = 1'b1; end
      ov[e * WO +: WO] = v[WO-1:0];
    end
  endfunction

  function automatic ev_t rand_ev();
    ev_t r;
    for (int i = 0; i < EW / 32; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic sv_t rand_sv();
    return sv_t'({$urandom, $urandom});
  endfunction

  task automatic drive_a(input ev_t ev, input sv_t sv, input logic [1:0] mode);
    bus_a.valid_in = 1'b1;
    bus_a.elems_in = ev;
    bus_a.scales_in = sv;
    bus_a.share_mode_in = mode;
  endtask

  // Returns just after the accepting edge with valid_in dropped.
  task automatic wait_accept_a();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = bus_a.ready_in;
      @(posedge clk); #1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout: ready_in stayed 0, required 1"); end
    bus_a.valid_in = 1'b0;
  endtask

  // Returns on a falling edge where valid_out is high.
  task automatic wait_valid_a();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus_a.valid_out) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL valid_timeout: valid_out stayed 0, required 1"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.valid_in = 0; bus_a.ready_out = 1; bus_a.elems_in = '0; bus_a.scales_in = '0; bus_a.share_mode_in = 0;
    bus_b.valid_in = 0; bus_b.ready_out = 1; bus_b.elems_in = '0; bus_b.scales_in = '0; bus_b.share_mode_in = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.valid_out); end
    checks++; if (bus_a.ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus_a.ready_in); end
    checks++; if (bus_a.elems_out !== '0) begin errors++; $display("FAIL reset_elems: got %h expected 0", bus_a.elems_out); end
    checks++; if (bus_a.sat_out !== 1'b0 || bus_a.err_out !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b err=%b expected 0 0", bus_a.sat_out, bus_a.err_out); end
    checks++; if (bus_b.valid_out !== 1'b0 || bus_b.ready_in !== 1'b1) begin errors++; $display("FAIL reset_b: got valid=%b ready=%b expected 0 1", bus_b.valid_out, bus_b.ready_in); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    ev_t ev = {NE{8'd3}};
    sv_t sv = {NS{3'd2}};
    ov_t exp, want = {NE{12'd12}};
    logic es;
    model(ev, sv, 2'd0, exp, es);
    bus_a.ready_out = 1'b1;
    drive_a(ev, sv, 2'd0);
    wait_accept_a();
    @(negedge clk);
    checks++; if (bus_a.valid_out !== 1'b0) begin errors++; $display("FAIL basic_lat_e0: got %b expected 0", bus_a.valid_out); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if (bus_a.valid_out !== 1'b0) begin errors++; $display("FAIL basic_lat_e1: got %b expected 0", bus_a.valid_out); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if (bus_a.valid_out !== 1'b1) begin errors++; $display("FAIL basic_lat_e2: got %b expected 1", bus_a.valid_out); end
    checks++; if (bus_a.elems_out !== want || bus_a.elems_out !== exp) begin errors++; $display("FAIL basic_elems: got %h expected %h", bus_a.elems_out, want); end
    checks++; if (bus_a.sat_out !== 1'b0 || bus_a.err_out !== 1'b0) begin errors++; $display("FAIL basic_flags: got sat=%b err=%b expected 0 0", bus_a.sat_out, bus_a.err_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    ev_t ev = rand_ev();
    sv_t sv = rand_sv();
    ov_t exp;
    logic es;
    ev[0 +: WI] = 8'd127; ev[WI +: WI] = 8'h80; ev[2*WI +: WI] = 8'd1; ev[3*WI +: WI] = 8'hFF;
    sv[0 +: SW] = 3'd5; sv[SW +: SW] = 3'd0;
    model(ev, sv, 2'd1, exp, es);
    drive_a(ev, sv, 2'd1);
    wait_accept_a();
    wait_valid_a();
    checks++; if (bus_a.elems_out[0 +: WO] !== 12'h7FF) begin errors++; $display("FAIL sat_pos: got %h expected 7ff", bus_a.elems_out[0 +: WO]); end
    checks++; if (bus_a.elems_out[WO +: WO] !== 12'h800) begin errors++; $display("FAIL sat_neg: got %h expected 800", bus_a.elems_out[WO +: WO]); end
    checks++; if (bus_a.elems_out[2*WO +: 2*WO] !== {12'hFE0, 12'h020}) begin errors++; $display("FAIL sat_share4: got %h expected fe0020", bus_a.elems_out[2*WO +: 2*WO]); end
    checks++; if (bus_a.sat_out !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b expected 1", bus_a.sat_out); end
    checks++; if (bus_a.elems_out !== exp) begin errors++; $display("FAIL sat_vector: got %h expected %h", bus_a.elems_out, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_modes();
    for (int i = 0; i < 6; i++) begin
      ev_t ev = rand_ev();
      sv_t sv = rand_sv();
      logic [1:0] mode = 2'(i % 3);
      ov_t exp;
      logic es;
      model(ev, sv, mode, exp, es);
      drive_a(ev, sv, mode);
      wait_accept_a();
      wait_valid_a();
      checks++; if (bus_a.elems_out !== exp) begin errors++; $display("FAIL rand_elems[%0d] mode %0d: got %h expected %h", i, mode, bus_a.elems_out, exp); end
      checks++; if (bus_a.sat_out !== es || bus_a.err_out !== 1'b0) begin errors++; $display("FAIL rand_flags[%0d]: got sat=%b err=%b expected %b 0", i, bus_a.sat_out, bus_a.err_out, es); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    ev_t ev[3];
    sv_t sv[3];
    ov_t exp[3];
    logic es[3];
    for (int i = 0; i < 3; i++) begin
      ev[i] = rand_ev(); sv[i] = rand_sv();
      model(ev[i], sv[i], 2'd0, exp[i], es[i]);
    end
    q_a.delete();
    bus_a.ready_out = 1'b0;
    drive_a(ev[0], sv[0], 2'd0);
    wait_accept_a();
    drive_a(ev[1], sv[1], 2'd0);
    wait_accept_a();
    drive_a(ev[2], sv[2], 2'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus_a.valid_out !== 1'b1 || bus_a.elems_out !== exp[0] || bus_a.sat_out !== es[0]) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b %h expected 1 %h", c, bus_a.valid_out, bus_a.elems_out, exp[0]); end
      checks++; if (bus_a.ready_in !== 1'b0) begin errors++; $display("FAIL bp_ready_low[%0d]: got %b expected 0", c, bus_a.ready_in); end
      @(posedge clk); #1;
    end
    bus_a.ready_out = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.ready_in !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %b expected 1", bus_a.ready_in); end
    @(posedge clk); #1;
    bus_a.valid_in = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.valid_out !== 1'b1 || bus_a.elems_out !== exp[1]) begin errors++; $display("FAIL bp_second: got valid=%b %h expected 1 %h", bus_a.valid_out, bus_a.elems_out, exp[1]); end
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (q_a.size() != 3) begin errors++; $display("FAIL bp_count: got %0d outputs expected 3", q_a.size()); end
    for (int i = 0; i < 3 && i < q_a.size(); i++) begin
      checks++; if (q_a[i] !== exp[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, q_a[i], exp[i]); end
    end
  endtask

  task automatic test_reserved();
    ev_t ev = rand_ev(), ev2 = rand_ev();
    sv_t sv = rand_sv(), sv2 = rand_sv();
    ov_t exp, exp2;
    logic es, es2;
    model(ev, sv, 2'd0, exp, es);
    model(ev2, sv2, 2'd0, exp2, es2);
    drive_a(ev, sv, 2'd3);
    wait_accept_a();
    wait_valid_a();
    checks++; if (bus_a.elems_out !== exp) begin errors++; $display("FAIL rsvd_elems: got %h expected %h", bus_a.elems_out, exp); end
    checks++; if (bus_a.err_out !== 1'b1 || bus_a.sat_out !== es) begin errors++; $display("FAIL rsvd_flags: got err=%b sat=%b expected 1 %b", bus_a.err_out, bus_a.sat_out, es); end
    @(posedge clk); #1;
    drive_a(ev2, sv2, 2'd0);
    wait_accept_a();
    wait_valid_a();
    checks++; if (bus_a.err_out !== 1'b0 || bus_a.elems_out !== exp2) begin errors++; $display("FAIL rsvd_next: got err=%b %h expected 0 %h", bus_a.err_out, bus_a.elems_out, exp2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    ev_t ev = rand_ev(), ev2 = rand_ev();
    sv_t sv = rand_sv(), sv2 = rand_sv();
    ov_t exp2;
    logic es2;
    model(ev2, sv2, 2'd2, exp2, es2);
    q_a.delete();
    drive_a(ev, sv, 2'd1);
    wait_accept_a();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.valid_out !== 1'b0 || bus_a.elems_out !== '0 || bus_a.sat_out !== 1'b0 || bus_a.err_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got valid=%b sat=%b err=%b %h expected all 0", bus_a.valid_out, bus_a.sat_out, bus_a.err_out, bus_a.elems_out); end
    checks++; if (bus_a.ready_in !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus_a.ready_in); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (q_a.size() != 0 || bus_a.valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got %0d outputs valid=%b expected 0 0", q_a.size(), bus_a.valid_out); end
    drive_a(ev2, sv2, 2'd2);
    wait_accept_a();
    wait_valid_a();
    checks++; if (bus_a.elems_out !== exp2 || bus_a.sat_out !== es2) begin errors++; $display("FAIL rstmid_next: got %h sat=%b expected %h %b", bus_a.elems_out, bus_a.sat_out, exp2, es2); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    ev_t ev[8];
    sv_t sv[8];
    logic [1:0] md[8];
    ov_t exp;
    logic es;
    q_b.delete(); qc_b.delete();
    bus_b.ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ev[i] = rand_ev(); sv[i] = rand_sv(); md[i] = 2'($urandom_range(0, 3));
      bus_b.valid_in = 1'b1; bus_b.elems_in = ev[i]; bus_b.scales_in = sv[i]; bus_b.share_mode_in = md[i];
      @(negedge clk);
      checks++; if (bus_b.ready_in !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus_b.ready_in); end
      @(posedge clk); #1;
    end
    bus_b.valid_in = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (q_b.size() != 8) begin errors++; $display("FAIL stream_count: got %0d outputs expected 8", q_b.size()); end
    for (int i = 0; i < 8 && i < q_b.size(); i++) begin
      model(ev[i], sv[i], md[i], exp, es);
      checks++; if (q_b[i] !== exp) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, q_b[i], exp); end
      if (i > 0) begin
        checks++; if (qc_b[i] != qc_b[i-1] + 1) begin errors++; $display("FAIL stream_gap[%0d]: got cycle %0d expected %0d", i, qc_b[i], qc_b[i-1] + 1); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random_modes();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
